garage_door_plant: RTL and testbench

//  Behavioural/synthesizable model of the door mechanism at the far end of the

---
 rtl/garage_door_pkg.sv | 34 +++
 rtl/garage_door_plant_step_prescaler.sv | 52 +++++
 rtl/garage_door_plant.sv | 130 +++++++++++++
 tb/tb_garage_door_plant.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/garage_door_pkg.sv
// ---------------------------------------------------------------------------
// garage_door_pkg
// Shared definitions for the garage door plant and its controller:
//   - plant_st_e : mechanism state codes reported on plant_st
//   - ctl_st_e   : controller state codes (idle / moving up / moving down)
//   - DEF_*      : default geometry and timing of the door mechanism
//   - is_moving  : true for the two states in which the door travels
// ---------------------------------------------------------------------------
package garage_door_pkg;

  typedef enum logic [2:0] {
    ST_PARKED  = 3'b000,
    ST_RISING  = 3'b001,
    ST_FALLING = 3'b010,
    ST_JAMMED  = 3'b011,
    ST_FAULT   = 3'b100
  } plant_st_e;

  typedef enum logic [1:0] {
    CTL_IDLE      = 2'd0,
    CTL_MOVING_UP = 2'd1,
    CTL_MOVING_DN = 2'd2
  } ctl_st_e;

  localparam int DEF_POS_W     = 4;
  localparam int DEF_TRAVEL    = 10;
  localparam int DEF_STEP_DIV  = 4;
  localparam int DEF_STALL_CYC = 8;

  function automatic logic is_moving(input plant_st_e st);
    return (st == ST_RISING) || (st == ST_FALLING);
  endfunction

endpackage

// File: rtl/garage_door_plant_step_prescaler.sv
// ---------------------------------------------------------------------------
// step_prescaler
// Modulo-STEP_DIV cycle counter that paces door motion.
// Ports:
//   clk     in  system clock, rising edge
//   nrst    in  asynchronous active-low reset
//   clr_i   in  restart the interval from zero (takes effect this cycle)
//   en_i    in  count this cycle
//   tick_o  out one-cycle pulse on the cycle the count wraps
// With en_i low and clr_i low the count holds, which is how the plant
// freezes motion timing while faulted.
// ---------------------------------------------------------------------------
module step_prescaler #(
  parameter int STEP_DIV = 4
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] base;

  always_comb begin
    // A restart counts the current cycle as the first of a fresh interval,
    // so a reversal waits the same STEP_DIV cycles as a start from rest.
    base   = clr_i ? '0 : cnt_q;
    tick_o = 1'b0;
    cnt_d  = cnt_q;
    if (en_i) begin
      tick_o = (base == TERM);
      cnt_d  = tick_o ? '0 : base + 1'b1;
    end else if (clr_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/garage_door_plant.sv
// ---------------------------------------------------------------------------
// garage_door_plant
// Synthesizable model of the door mechanism driven by the garage door
// controller. Integrates motor_up/motor_dn into a position counter and
// decodes the limit switches from it, closing the control loop.
// Ports:
//   clk       in  system clock, rising edge
//   nrst      in  asynchronous active-low reset
//   motor_up  in  controller drives door upward
//   motor_dn  in  controller drives door downward
//   up_limit  out position == TRAVEL
//   dn_limit  out position == 0
//   position  out current door position (POS_W bits)
//   plant_st  out mechanism state code (plant_st_e)
//   stall     out motor held against its limit for >= STALL_CYC cycles
//   fault     out sticky, both motor inputs were seen high together
// ---------------------------------------------------------------------------
module garage_door_plant
  import garage_door_pkg::*;
#(
  parameter int POS_W     = DEF_POS_W,
  parameter int TRAVEL    = DEF_TRAVEL,
  parameter int STEP_DIV  = DEF_STEP_DIV,
  parameter int STALL_CYC = DEF_STALL_CYC,
  parameter int RESET_POS = 0
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             motor_up,
  input  logic             motor_dn,
  output logic             up_limit,
  output logic             dn_limit,
  output logic [POS_W-1:0] position,
  output logic [2:0]       plant_st,
  output logic             stall,
  output logic             fault
);

  localparam logic [POS_W-1:0] POS_TOP = POS_W'(TRAVEL);
  localparam logic [POS_W-1:0] POS_RST = POS_W'(RESET_POS);
  localparam int               STALL_W = $clog2(STALL_CYC + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYC);

  plant_st_e          state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               fault_q, fault_d;
  logic               at_top, at_bottom;
  logic               presc_en, presc_clr, step_tick;

  assign at_top    = (pos_q == POS_TOP);
  assign at_bottom = (pos_q == '0);

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_PARKED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; FAULT outranks everything and is absorbing.
  always_comb begin
    state_d = ST_PARKED;
    if ((state_q == ST_FAULT) || (motor_up && motor_dn)) begin
      state_d = ST_FAULT;
    end else if (motor_up) begin
      state_d = at_top ? ST_JAMMED : ST_RISING;
    end else if (motor_dn) begin
      state_d = at_bottom ? ST_JAMMED : ST_FALLING;
    end
  end

  // Outputs and datapath next values
  always_comb begin
    // Count whenever the door travels this cycle; restart the interval on a
    // fresh start or reversal, and zero it when parked or jammed. In FAULT
    // neither is asserted, so the prescaler holds.
    presc_en  = is_moving(state_d);
    presc_clr = (state_d == ST_PARKED) || (state_d == ST_JAMMED) ||
                (is_moving(state_d) && (state_d != state_q));

    // RISING/FALLING are only entered away from the matching limit, so the
    // step below can never overshoot TRAVEL or underflow 0.
    pos_d = pos_q;
    if (step_tick && (state_d == ST_RISING)) begin
      pos_d = pos_q + 1'b1;
    end else if (step_tick && (state_d == ST_FALLING)) begin
      pos_d = pos_q - 1'b1;
    end

    stall_cnt_d = '0;
    if (state_d == ST_JAMMED) begin
      stall_cnt_d = (stall_cnt_q == STALL_MAX) ? stall_cnt_q : stall_cnt_q + 1'b1;
    end

    fault_d = fault_q || (state_d == ST_FAULT);

    up_limit = at_top;
    dn_limit = at_bottom;
    position = pos_q;
    plant_st = state_q;
    stall    = (stall_cnt_q == STALL_MAX);
    fault    = fault_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pos_q       <= POS_RST;
      stall_cnt_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      pos_q       <= pos_d;
      stall_cnt_q <= stall_cnt_d;
      fault_q     <= fault_d;
    end
  end

  step_prescaler #(
    .STEP_DIV (STEP_DIV)
  ) u_step_prescaler (
    .clk    (clk),
    .nrst   (nrst),
    .clr_i  (presc_clr),
    .en_i   (presc_en),
    .tick_o (step_tick)
  );

endmodule

// File: tb/tb_garage_door_plant.sv
module tb_garage_door_plant;

  localparam int POS_W     = 4;
  localparam int TRAVEL    = 5;
  localparam int STEP_DIV  = 2;
  localparam int STALL_CYC = 4;
  localparam int RESET_POS = 0;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic             motor_up = 1'b0;
  logic             motor_dn = 1'b0;
  logic             up_limit, dn_limit, stall, fault;
  logic [POS_W-1:0] position;
  logic [2:0]       plant_st;

  always #5 clk = ~clk;

  garage_door_plant #(
    .POS_W     (POS_W),
    .TRAVEL    (TRAVEL),
    .STEP_DIV  (STEP_DIV),
    .STALL_CYC (STALL_CYC),
    .RESET_POS (RESET_POS)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .motor_up (motor_up),
    .motor_dn (motor_dn),
    .up_limit (up_limit),
    .dn_limit (dn_limit),
    .position (position),
    .plant_st (plant_st),
    .stall    (stall),
    .fault    (fault)
  );

  typedef struct packed {
    logic [3:0] pos;
    logic       up_lim;
    logic       dn_lim;
    logic [2:0] st;
    logic       stall;
    logic       fault;
  } obs_t;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: door position, how long the motor has been driven in
  // the current direction, how long it has been pushed against a limit.
  int m_pos, m_dir, m_run, m_jam, m_st;
  bit m_fault;

  function automatic void model_reset();
    m_pos = RESET_POS; m_dir = 0; m_run = 0; m_jam = 0; m_st = 0; m_fault = 0;
  endfunction

  function automatic void model_edge(input bit up, input bit dn);
    int d;
    if (m_fault || (up && dn)) begin
      m_fault = 1; m_st = 4; m_jam = 0;
    end else if ((up && m_pos == TRAVEL) || (dn && m_pos == 0)) begin
      m_st = 3; m_jam++; m_dir = 0; m_run = 0;
    end else if (up || dn) begin
      d = up ? 1 : -1;
      if (d != m_dir) begin m_dir = d; m_run = 0; end
      m_run++;
      if (m_run == STEP_DIV) begin m_pos += d; m_run = 0; end
      m_st = up ? 1 : 2;
      m_jam = 0;
    end else begin
      m_st = 0; m_dir = 0; m_run = 0; m_jam = 0;
    end
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.pos    = 4'(m_pos);
    o.up_lim = (m_pos == TRAVEL);
    o.dn_lim = (m_pos == 0);
    o.st     = 3'(m_st);
    o.stall  = (m_jam >= STALL_CYC);
    o.fault  = m_fault;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.pos = position; o.up_lim = up_limit; o.dn_lim = dn_limit;
    o.st = plant_st; o.stall = stall; o.fault = fault;
    return o;
  endfunction

  function automatic void compare(input string name, input obs_t a, input obs_t e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s t=%0t got pos=%0d up=%b dn=%b st=%0d stall=%b fault=%b exp pos=%0d up=%b dn=%b st=%0d stall=%b fault=%b",
               name, $time, a.pos, a.up_lim, a.dn_lim, a.st, a.stall, a.fault,
               e.pos, e.up_lim, e.dn_lim, e.st, e.stall, e.fault);
    end else begin
      $display("[TB] ok %s t=%0t up=%b dn=%b pos=%0d st=%0d stall=%b fault=%b",
               name, $time, motor_up, motor_dn, a.pos, a.st, a.stall, a.fault);
    end
  endfunction

  // Monitor: the plant presents a fresh observation after every edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        compare("edge", dut_obs(), exp_q.pop_front());
      end
    end
  end

  task automatic drive(input bit up, input bit dn);
    @(negedge clk);
    motor_up = up;
    motor_dn = dn;
    model_edge(up, dn);
    exp_q.push_back(model_obs());
  endtask

  // Asynchronous reset pulse placed mid-cycle, checked before the next edge.
  task automatic reset_pulse(input bit up, input bit dn);
    @(negedge clk);
    #1 nrst = 1'b0;
    motor_up = up;
    motor_dn = dn;
    #1;
    model_reset();
    compare("async_reset", dut_obs(), model_obs());
    #1 nrst = 1'b1;
    model_edge(up, dn);
    exp_q.push_back(model_obs());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t simulation did not complete", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, len;
    bit up, dn;
    model_reset();
    reset_pulse(1'b0, 1'b0);

    // Rise to the top, stall there, then release.
    repeat (16) drive(1'b1, 1'b0);
    repeat (2) drive(1'b0, 1'b0);
    // Descend to 3, then reverse upward, then reverse again.
    repeat (4) drive(1'b0, 1'b1);
    repeat (3) drive(1'b1, 1'b0);
    repeat (3) drive(1'b0, 1'b1);
    // Single-cycle conflict: sticky fault, position frozen.
    drive(1'b1, 1'b1);
    repeat (4) drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    reset_pulse(1'b0, 1'b0);
    // Reset while rising at position 3.
    repeat (6) drive(1'b1, 1'b0);
    reset_pulse(1'b1, 1'b0);
    repeat (4) drive(1'b1, 1'b0);
    // Bottom jam.
    repeat (6) drive(1'b0, 1'b1);

    for (int blk = 0; blk < 150; blk++) begin
      r = $urandom_range(0, 99);
      up = (r < 40) || (r >= 95);
      dn = ((r >= 40) && (r < 80)) || (r >= 95);
      len = $urandom_range(1, 12);
      if (($urandom_range(0, 19) == 0) || (m_fault && $urandom_range(0, 2) == 0)) begin
        reset_pulse(up, dn);
        len--;
      end
      for (int i = 0; i < len; i++) drive(up, dn);
    end

    drive(1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
